// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game blocks.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOST = 2'b10,
    ST_WON  = 2'b11
  } game_state_t;

  localparam int X_W      = 7;
  localparam int Y_W      = 6;
  localparam int SCORE_W  = 4;
  localparam int PERIOD_W = 23;
  localparam int PROD_W   = PERIOD_W + SCORE_W;

  localparam logic [SCORE_W-1:0] MAX_SCORE = 4'd15;

  // Move period for a given score. It never drops below min_p and never wraps.
  function automatic logic [PERIOD_W-1:0] calc_period(
    input logic [SCORE_W-1:0]  score,
    input logic [PERIOD_W-1:0] base,
    input logic [PERIOD_W-1:0] step,
    input logic [PERIOD_W-1:0] min_p
  );
    logic [PROD_W-1:0] dec;
    logic [PROD_W-1:0] span;
    dec  = PROD_W'(score) * PROD_W'(step);
    span = '0;
    if (base <= min_p) return min_p;
    span = PROD_W'(base - min_p);
    if (dec >= span) return min_p;
    return base - dec[PERIOD_W-1:0];
  endfunction

endpackage

// File: rtl/snake_game_ctrl_tick_timer.sv
// Movement timer: counts 0..period-1 while running and flags the last count.
// The period is latched at each restart, so a period already in progress is
// never shortened by a score change.
module tick_timer
  import snake_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                restart,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count_q;
  logic [PERIOD_W-1:0] period_q;

  assign tick = run & (count_q == (period_q - PERIOD_W'(1)));

  // Count register; wraps to zero and reloads the period on every tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      period_q <= '0;
    end else if (restart) begin
      count_q  <= '0;
      period_q <= period;
    end else if (run) begin
      if (tick) begin
        count_q  <= '0;
        period_q <= period;
      end else begin
        count_q <= count_q + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Round sequencer for the snake game: start handling, move tick, evaluation of
// collision/food flags two cycles after each tick, and the score register.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_BASE = 4_000_000,
  parameter int TICK_STEP = 200_000,
  parameter int TICK_MIN  = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               game_over,
  input  logic               victory,
  input  logic               food_hit,
  output logic [1:0]         state,
  output logic               move_tick,
  output logic               grow,
  output logic               clear,
  output logic [SCORE_W-1:0] score
);

  localparam logic [PERIOD_W-1:0] BASE_P = PERIOD_W'(TICK_BASE);
  localparam logic [PERIOD_W-1:0] STEP_P = PERIOD_W'(TICK_STEP);
  localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(TICK_MIN);

  game_state_t         state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                start_q;
  logic                start_edge;
  logic                start_round;
  logic                grow_c;
  logic [1:0]          eval_pipe;
  logic                eval;
  logic                move_tick_q;
  logic                clear_q;
  logic                timer_tick;
  logic [PERIOD_W-1:0] period;

  assign start_edge = start & ~start_q;
  assign eval       = eval_pipe[1];

  // A new round always starts from score 0, so the restart loads that period.
  assign period = calc_period(start_round ? '0 : score_q, BASE_P, STEP_P, MIN_P);

  tick_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (state_q == ST_RUN),
    .restart (start_round),
    .period  (period),
    .tick    (timer_tick)
  );

  // Next-state, score update and grow decision; grow is combinational so it
  // lines up with the eval cycle two cycles after move_tick.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    start_round = 1'b0;
    grow_c      = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOST, ST_WON: begin
        if (start_edge) begin
          state_d     = ST_RUN;
          score_d     = '0;
          start_round = 1'b1;
        end
      end
      ST_RUN: begin
        if (eval) begin
          if (game_over) begin
            state_d = ST_LOST;
          end else if (victory) begin
            state_d = ST_WON;
          end else if (food_hit) begin
            grow_c = 1'b1;
            if (score_q != MAX_SCORE) score_d = score_q + SCORE_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, score, edge detector, eval delay line and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      score_q     <= '0;
      start_q     <= 1'b0;
      eval_pipe   <= '0;
      move_tick_q <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      start_q     <= start;
      eval_pipe   <= {eval_pipe[0], move_tick_q};
      move_tick_q <= timer_tick & (state_d == ST_RUN);
      clear_q     <= start_round;
    end
  end

  assign state     = state_q;
  assign score     = score_q;
  assign move_tick = move_tick_q;
  assign clear     = clear_q;
  assign grow      = grow_c;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl against an event-scheduled model.
module tb_snake_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  logic       victory = 1'b0;
  logic       food_hit = 1'b0;
  logic [1:0] state;
  logic       move_tick;
  logic       grow;
  logic       clear;
  logic [3:0] score;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: round state, score, scheduled tick and eval cycles.
  int m_state = 0;
  int m_score = 0;
  int m_next_tick = 0;
  int m_evals[$];
  bit m_prev_start = 0;
  bit m_clear_pend = 0;
  int cyc = 0;

  snake_game_ctrl #(.TICK_BASE(20), .TICK_STEP(2), .TICK_MIN(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .game_over (game_over),
    .victory   (victory),
    .food_hit  (food_hit),
    .state     (state),
    .move_tick (move_tick),
    .grow      (grow),
    .clear     (clear),
    .score     (score)
  );

  always #5 clk = ~clk;

  function automatic int period_of(input int s);
    int p;
    p = 20 - s * 2;
    if (p < 8) p = 8;
    return p;
  endfunction

  // One clock cycle: drive inputs after the edge, sample at the falling edge,
  // and advance the model. Outputs packed as {state, score, tick, grow, clear}.
  task automatic run_cycle(input logic s, input logic go, input logic vic, input logic food,
                           output logic [8:0] obs, output logic [8:0] exp);
    logic e_tick, e_grow, e_clear, ev, edge_s;
    @(posedge clk); #1;
    reset = 1'b0; start = s; game_over = go; victory = vic; food_hit = food;
    @(negedge clk);
    obs = {state, score, move_tick, grow, clear};
    e_tick = (m_state == 1) && (cyc == m_next_tick);
    ev = (m_evals.size() > 0) && (m_evals[0] == cyc);
    if (ev) void'(m_evals.pop_front());
    e_grow = ev && (m_state == 1) && !go && !vic && food;
    e_clear = m_clear_pend;
    exp = {m_state[1:0], m_score[3:0], e_tick, e_grow, e_clear};
    edge_s = s && !m_prev_start;
    m_prev_start = s;
    m_clear_pend = 0;
    if (m_state != 1) begin
      if (edge_s) begin
        m_state = 1; m_score = 0; m_clear_pend = 1;
        m_next_tick = cyc + 1 + period_of(0);
        m_evals.delete();
      end
    end else begin
      if (e_tick) begin
        m_next_tick = cyc + period_of(m_score);
        m_evals.push_back(cyc + 2);
      end
      if (ev) begin
        if (go) m_state = 2;
        else if (vic) m_state = 3;
        else if (food && m_score < 15) m_score = m_score + 1;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; game_over = 1'b0; victory = 1'b0; food_hit = 1'b0;
    m_state = 0; m_score = 0; m_prev_start = 0; m_clear_pend = 0;
    m_evals.delete();
    cyc++;
  endtask

  // Runs until a move_tick and one more cycle, so the next cycle is the eval.
  task automatic advance_to_eval(input string name, input logic hold_start, input logic food);
    logic [8:0] o, e;
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      run_cycle(hold_start, 0, 0, food, o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("[TB] FAIL %s cyc=%0d got=%b expected=%b", name, cyc, o, e); end
      if (e[2]) seen = 1;
    end
    if (!seen) begin
      n_checks++; n_fails++;
      $display("[TB] FAIL %s timeout got=no_tick expected=tick", name);
    end
    run_cycle(hold_start, 0, 0, food, o, e);
    n_checks++;
    if (o !== e) begin n_fails++; $display("[TB] FAIL %s cyc=%0d got=%b expected=%b", name, cyc, o, e); end
  endtask

  task automatic test_reset();
    logic [8:0] o, e;
    do_reset();
    run_cycle(0, 0, 0, 0, o, e);
    n_checks++;
    if (o !== e) begin n_fails++; $display("[TB] FAIL reset_model got=%b expected=%b", o, e); end
    n_checks++;
    if (o !== 9'b0) begin n_fails++; $display("[TB] FAIL reset_values got=%b expected=%b", o, 9'b0); end
  endtask

  task automatic test_start_ticks();
    logic [8:0] o, e;
    int ticks = 0;
    do_reset();
    run_cycle(1, 0, 0, 0, o, e);
    for (int i = 0; i < 64; i++) begin
      run_cycle(0, 0, 0, 0, o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("[TB] FAIL start_ticks cyc=%0d got=%b expected=%b", cyc, o, e); end
      if (i == 0) begin
        n_checks++;
        if (o[0] !== 1'b1 || o[8:7] !== 2'b01) begin n_fails++; $display("[TB] FAIL start_clear got=%b expected=clear,RUN", o); end
      end
      if (o[2] === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks != 3) begin n_fails++; $display("[TB] FAIL tick_count got=%0d expected=3", ticks); end
  endtask

  task automatic test_food_growth();
    logic [8:0] o, e;
    do_reset();
    run_cycle(1, 0, 0, 0, o, e);
    for (int i = 0; i < 300; i++) begin
      run_cycle(0, 0, 0, 1, o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("[TB] FAIL food_growth cyc=%0d got=%b expected=%b", cyc, o, e); end
    end
    n_checks++;
    if (score !== 4'd15) begin n_fails++; $display("[TB] FAIL score_saturate got=%0d expected=15", score); end
  endtask

  task automatic test_lost();
    logic [8:0] o, e;
    do_reset();
    run_cycle(1, 0, 0, 0, o, e);
    for (int t = 0; t < 3; t++) begin
      advance_to_eval("lost_adv", 0, 0);
      run_cycle(0, (t == 2), 0, 0, o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("[TB] FAIL lost_eval cyc=%0d got=%b expected=%b", cyc, o, e); end
    end
    for (int i = 0; i < 40; i++) begin
      run_cycle(0, 0, 0, 0, o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("[TB] FAIL lost_hold cyc=%0d got=%b expected=%b", cyc, o, e); end
    end
    n_checks++;
    if (state !== 2'b10) begin n_fails++; $display("[TB] FAIL lost_state got=%b expected=10", state); end
    run_cycle(1, 0, 0, 0, o, e);
    run_cycle(0, 0, 0, 0, o, e);
    n_checks++;
    if (o !== e || o[0] !== 1'b1 || o[6:3] !== 4'd0 || o[8:7] !== 2'b01) begin
      n_fails++; $display("[TB] FAIL lost_restart got=%b expected=%b", o, e);
    end
  endtask

  task automatic test_priority();
    logic [8:0] o, e;
    do_reset();
    run_cycle(1, 0, 0, 0, o, e);
    advance_to_eval("prio_adv", 0, 0);
    run_cycle(0, 1, 1, 0, o, e);
    run_cycle(0, 0, 0, 0, o, e);
    n_checks++;
    if (o[8:7] !== 2'b10 || o !== e) begin n_fails++; $display("[TB] FAIL prio_lost got=%b expected=%b", o, e); end
    run_cycle(1, 0, 0, 0, o, e);
    advance_to_eval("prio_adv", 0, 0);
    run_cycle(0, 0, 1, 0, o, e);
    run_cycle(0, 0, 0, 0, o, e);
    n_checks++;
    if (o[8:7] !== 2'b11 || o !== e) begin n_fails++; $display("[TB] FAIL prio_won got=%b expected=%b", o, e); end
    run_cycle(1, 0, 0, 0, o, e);
    advance_to_eval("prio_adv", 0, 0);
    run_cycle(0, 1, 0, 1, o, e);
    n_checks++;
    if (o[1] !== 1'b0 || o !== e) begin n_fails++; $display("[TB] FAIL prio_nogrow got=%b expected=%b", o, e); end
  endtask

  task automatic test_ignored();
    logic [8:0] o, e;
    int clears = 0;
    bit go;
    do_reset();
    for (int i = 0; i < 90; i++) begin
      go = (i % 7 == 3) && !(m_evals.size() > 0 && m_evals[0] == cyc);
      run_cycle(1, go, 0, 0, o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("[TB] FAIL ignored cyc=%0d got=%b expected=%b", cyc, o, e); end
      if (o[0] === 1'b1) clears++;
    end
    n_checks++;
    if (clears != 1 || state !== 2'b01) begin
      n_fails++; $display("[TB] FAIL ignored_summary got=clears %0d state %b expected=clears 1 state 01", clears, state);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] o, e;
    do_reset();
    run_cycle(1, 0, 0, 0, o, e);
    advance_to_eval("rmid_adv", 0, 1);
    run_cycle(0, 0, 0, 1, o, e);
    run_cycle(0, 0, 0, 1, o, e);
    run_cycle(0, 0, 0, 1, o, e);
    do_reset();
    run_cycle(0, 0, 0, 1, o, e);
    n_checks++;
    if (o !== 9'b0) begin n_fails++; $display("[TB] FAIL reset_mid got=%b expected=%b", o, 9'b0); end
    for (int i = 0; i < 30; i++) begin
      run_cycle(0, 0, 0, 1, o, e);
      n_checks++;
      if (o !== e || o[1] !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_mid_after cyc=%0d got=%b expected=%b", cyc, o, e); end
    end
  endtask

  task automatic test_random();
    logic [8:0] o, e;
    logic s, go, vic, food;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      s    = ($urandom_range(0, 19) == 0);
      go   = ($urandom_range(0, 5) == 0);
      vic  = ($urandom_range(0, 7) == 0);
      food = ($urandom_range(0, 1) == 0);
      run_cycle(s, go, vic, food, o, e);
      n_checks++;
      if (o !== e) begin n_fails++; $display("[TB] FAIL random cyc=%0d got=%b expected=%b", cyc, o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_start_ticks();
    test_food_growth();
    test_lost();
    test_priority();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Round sequencer for the snake game. It turns the start button into a round, produces the movement tick that advances head and tail, and samples the collision block's `game_over`/`victory` flags and the food-hit flag. It also keeps the 0..15 score that feeds back into the collision block. It sits between the debounced button inputs and the snake datapath (head/tail registers, collision detector, food generator).

## Interface
- `TICK_BASE`, default 4_000_000: cycles per move at score 0.
- `TICK_STEP`, default 200_000: cycles removed from the move period per score point.
- `TICK_MIN`, default 1_000_000: lower clamp on the move period.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `start` in 1: debounced start button, level.
- `game_over` in 1: registered collision flag from the collision block.
- `victory` in 1: registered win flag from the collision block.
- `food_hit` in 1: head coordinate equals food coordinate, level.
- `state` out 2: IDLE=00, RUN=01, LOST=10, WON=11.
- `move_tick` out 1: one-cycle strobe; the datapath steps head and tail.
- `grow` out 1: one-cycle strobe; the tail gains a segment and the food generator relocates.
- `clear` out 1: one-cycle strobe; reinitialises the snake and resets the collision block.
- `score` out 4: segments eaten, 0..15.

## Operation
- Start edge: `start_edge = start & ~start_q`, with `start_q` registered every cycle.
- **IDLE:**
  - On `start_edge`: pulse `clear`, zero `score` and the timer, go to RUN.
  - Otherwise stay in IDLE.
- **RUN:**
  - Timer counts 0..P-1, with P = max(TICK_BASE − score·TICK_STEP, TICK_MIN).
  - At count P-1: pulse `move_tick` and restart the timer at 0.
  - `start_edge` is ignored.
- **Evaluation:**
  - `eval` is `move_tick` delayed 2 cycles, to cover the head update plus the collision register.
  - At `eval`, in priority order:
    - `game_over` → LOST.
    - else `victory` → WON.
    - else `food_hit` → pulse `grow` and set score = score+1, saturating at 15.
  - `game_over`, `victory` and `food_hit` are ignored outside `eval`.
- **LOST / WON:**
  - Timer frozen, no `move_tick`, `score` held for display.
  - On `start_edge`: same actions as from IDLE (pulse `clear`, zero score and timer, enter RUN).
- Arithmetic:
  - The period uses 23-bit unsigned arithmetic.
  - The product score·TICK_STEP is computed at ≥23 bits.
  - If TICK_STEP·score ≥ TICK_BASE − TICK_MIN, the period clamps to TICK_MIN; it never underflows.
- A score change takes effect from the next timer restart. The period in progress is not shortened.

## Timing
- Reset values:
  - `state`=IDLE, `score`=0, `move_tick`=0, `grow`=0, `clear`=0.
  - Timer=0, `start_q`=0, eval pipeline=0.
- `reset` asserted mid-round: the next edge forces all reset values and discards any pending `eval`.
- `clear` is asserted in the cycle after the edge that registers `start_edge`; the state is RUN in that same cycle.
- First `move_tick` comes P cycles after entering RUN; later ticks come every P cycles.
- `grow` and the score increment occur in the same cycle, exactly 2 cycles after `move_tick`.
- Entry into LOST/WON occurs at `eval`. `move_tick` is never asserted in the cycle after that entry.
- `move_tick`, `grow` and `clear` are each high for exactly one cycle. `clear` and `move_tick` are never high together.
- Stale `game_over` from the previous round is still high for 1 cycle after `clear`. It cannot be sampled, because the first `eval` is ≥ TICK_MIN+2 cycles later.

## Structure
- Shared package `snake_pkg`:
  - State encodings.
  - `MAX_SCORE`=15.
  - Coordinate widths (x 7, y 6) and the score width (4), shared with the collision block and the tail shifter.
- One sub-module, `tick_timer`:
  - Inputs: `clk`, `reset`, `run` (enable), `restart`, `period[22:0]`.
  - Output: `tick`.
  - Holds its count when `run`=0.
- The controller holds the FSM, the start edge detector, the eval delay line, the score register and the period computation.

## Test plan
All scenarios use TICK_BASE=20, TICK_STEP=2, TICK_MIN=8.
- Reset then one `start` pulse → `clear` high for 1 cycle, state=RUN, first `move_tick` 20 cycles later, then every 20 cycles.
- `food_hit`=1 held steadily through the round → `grow` 2 cycles after each tick. Score goes 1,2,3… and the period goes 18,16,…; from score 6 it stays clamped at 8. Score saturates at 15.
- `game_over` raised 2 cycles after the 3rd tick → state=LOST, no further `move_tick`, score frozen at its value. A later `start` edge → `clear`, score=0, RUN.
- `game_over` and `victory` both high at `eval` → LOST, not WON. `victory` alone → WON. `food_hit` together with `game_over` → no `grow`.
- `game_over` pulsed between evals, and `start` held high for the whole RUN state → no state change and no `clear`.
- `reset` asserted 5 cycles after a `move_tick` → state=IDLE and score=0 next cycle, no `grow` afterwards.
